rram_bank: RTL and testbench
============================

# rram_bank

Parametrised single-port register-file memory with a request/ready handshake, per-byte write enables, a registered read-data path with a valid strobe, and an optional post-reset clear sequencer. It is the next-generation storage block for datapath buffers. It replaces flat reset of every entry with a one-entry-per-cycle clear state machine, so large depths stay synthesisable. Clients sit on the request side; the array is internal.

## Interface
- WIDTH, 32, data word width in bits; must be a multiple of 8
- DEPTH, 2048, number of words; need not be a power of 2
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  request valid
- i_rw_n  in  1  1 = read, 0 = write
- i_adr  in  ADDR_W  word address
- i_data  in  WIDTH  write data
- i_be  in  WIDTH/8  byte write enables; bit k covers i_data[8k+7:8k]
- o_ready  out  1  block can accept a request this cycle
- o_valid  out  1  o_data carries read result (1-cycle pulse per read)
- o_data  out  WIDTH  read data
- o_err  out  1  1-cycle pulse: accepted request had i_adr >= DEPTH
- o_init_done  out  1  high once clear sequence has finished (or immediately, see Configuration)

## Operation
- FSM states: INIT (clearing array) and RUN. Reset enters INIT.
- INIT behaviour:
  - Writes 0 to entry clr_cnt; clr_cnt increments 0..DEPTH-1.
  - Moves to RUN after the write to DEPTH-1.
  - o_ready = 0 throughout; requests are ignored (no o_valid, no o_err, no array change).
- RUN: o_ready = 1 every cycle. The block never back-pressures once initialised.
- A request is accepted on a rising edge with i_req && o_ready.
- Accepted write, in range: for each byte k with i_be[k] = 1, the array byte is updated from i_data. Other bytes are unchanged. i_be = 0 is a legal no-op.
- Accepted read, in range: o_data is loaded with array[i_adr]. o_valid is asserted.
- Out of range (i_adr >= DEPTH):
  - Write: the array is unchanged.
  - Read: o_data = 0 and o_valid = 1.
  - Both cases: o_err pulses.
- o_data holds its last value between reads. It is not cleared by writes.
- Reset values: o_ready 0, o_valid 0, o_data 0, o_err 0, o_init_done 0, clr_cnt 0, state INIT. Array contents are not reset directly; only the INIT sequence clears them.
- Reset asserted mid-INIT or mid-RUN: all outputs go to reset values immediately (asynchronous). On release the clear restarts from entry 0.

## Timing
- Read latency is 1 cycle. A read accepted at edge N gives o_valid = 1 and o_data valid after edge N, for exactly one cycle unless another read is accepted at edge N+1.
- Back-to-back reads: one per cycle, full throughput, o_valid held high continuously.
- Write then read of the same address on consecutive edges returns the new data. The write commits at edge N; the read accepted at N+1 sees it.
- Write-to-read forwarding within the same cycle is not possible: the port is single, so one operation per edge.
- Clear duration: INIT lasts exactly DEPTH cycles after rst_n deasserts. o_ready and o_init_done rise together at the edge that completes the write to entry DEPTH-1.
- o_err is aligned with o_valid for reads and pulses 1 cycle after acceptance for writes.

## Configuration
- Macro: RRAM_BANK_INIT_CLEAR_EN.
- Defined: the INIT clear sequencer is compiled in and behaves as described above.
- Undefined:
  - The INIT state and clr_cnt are removed.
  - The block enters RUN on the first rising edge after rst_n deasserts; o_ready and o_init_done go to 1 there.
  - Array contents after reset are undefined. The bench must treat unwritten reads as X.

## Test plan
- Clear (macro defined, WIDTH=32, DEPTH=2048), release rst_n → o_ready low for exactly 2048 cycles, then high. Reads of addresses 0, 1023 and 2047 return 0x00000000.
- Byte enables: write 0xAABBCCDD to address 5 with i_be=4'hF, then 0x11223344 with i_be=4'b0101, then read address 5 → o_data = 0xAA22CC44 with o_valid one cycle after acceptance.
- Back-to-back: write addresses 0..7 with data = address × 0x01010101, then 8 consecutive reads → o_valid high for 8 consecutive cycles with data in order.
- Out of range (DEPTH=1000, ADDR_W=10): write 0xDEADBEEF to address 1000, then read 1000 → o_err pulses twice, read o_data = 0. A read of address 999 is unaffected.
- Reset mid-INIT: assert rst_n low at INIT cycle 500, release → o_ready stays low for a full 2048 cycles. Requests issued during INIT produce no o_valid.
- Macro undefined: release rst_n → o_ready = 1 one cycle later. Write then read address 3 with 0x12345678 returns 0x12345678.

Source files
------------

// File: rtl/rram_bank.sv
// Single-port register-file bank: byte-enabled writes, registered read path, range-error strobe.
// Define RRAM_BANK_INIT_CLEAR_EN to compile in the post-reset clear sequencer.
module rram_bank #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 2048,
   parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_req,
   input  logic                 i_rw_n,
   input  logic [ADDR_W-1:0]    i_adr,
   input  logic [WIDTH-1:0]     i_data,
   input  logic [WIDTH/8-1:0]   i_be,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [WIDTH-1:0]     o_data,
   output logic                 o_err,
   output logic                 o_init_done
);

   localparam int unsigned BE_W  = WIDTH / 8;
   localparam int unsigned CMP_W = 32;

`ifdef RRAM_BANK_INIT_CLEAR_EN
   typedef enum logic {ST_INIT, ST_RUN} state_t;
   localparam state_t ST_RESET = ST_INIT;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`else
   typedef enum logic {ST_WAKE, ST_RUN} state_t;
   localparam state_t ST_RESET = ST_WAKE;
`endif

   state_t state_q, state_d;
   logic   ready_d;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_adr;
   logic [WIDTH-1:0]   mem_wdata;
   logic [BE_W-1:0]    mem_be;
   logic [WIDTH-1:0]   mem [DEPTH];

   logic acc;
   logic in_range;

   assign acc      = i_req && o_ready;
   assign in_range = CMP_W'(i_adr) < DEPTH;

   // Next-state and array-port steering
   always_comb begin
      state_d   = state_q;
      ready_d   = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = i_adr;
      mem_wdata = i_data;
      mem_be    = i_be;
`ifdef RRAM_BANK_INIT_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
`endif
      case (state_q)
`ifdef RRAM_BANK_INIT_CLEAR_EN
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_adr   = clr_cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (CMP_W'(clr_cnt_q) == DEPTH - 1) begin
               state_d   = ST_RUN;
               ready_d   = 1'b1;
               clr_cnt_d = '0;
            end
         end
`else
         ST_WAKE: begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
`endif
         ST_RUN: begin
            ready_d = 1'b1;
            mem_we  = acc && !i_rw_n && in_range;
         end
         default: state_d = ST_RESET;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
`ifdef RRAM_BANK_INIT_CLEAR_EN
         clr_cnt_q   <= '0;
`endif
         o_ready     <= 1'b0;
         o_init_done <= 1'b0;
         o_valid     <= 1'b0;
         o_data      <= '0;
         o_err       <= 1'b0;
      end else begin
         state_q     <= state_d;
`ifdef RRAM_BANK_INIT_CLEAR_EN
         clr_cnt_q   <= clr_cnt_d;
`endif
         o_ready     <= ready_d;
         o_init_done <= ready_d;
         o_valid     <= acc && i_rw_n;
         o_err       <= acc && !in_range;
         if (acc && i_rw_n) begin
            o_data <= in_range ? mem[i_adr] : '0;
         end
      end
   end

   // Storage array: no reset, cleared only by the sequencer
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned k = 0; k < BE_W; k++) begin
            if (mem_be[k]) begin
               mem[mem_adr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_rram_bank.sv
// Self-checking bench for rram_bank: directed scenarios plus randomized traffic against a word-array model.
module tb_rram_bank;

   localparam int unsigned W     = 32;
   localparam int unsigned DA    = 2048;
   localparam int unsigned AWA   = 11;
   localparam int unsigned DB    = 1000;
   localparam int unsigned AWB   = 10;
   localparam int unsigned LIMIT = DA + 32;
`ifdef RRAM_BANK_INIT_CLEAR_EN
   localparam int unsigned INIT_CYC = DA;
   localparam logic [3:0]  KN_RST   = 4'hF;
`else
   localparam int unsigned INIT_CYC = 1;
   localparam logic [3:0]  KN_RST   = 4'h0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic           req, rw_n, ready, valid, err, init_done;
   logic [AWA-1:0] adr;
   logic [W-1:0]   data, rdata;
   logic [3:0]     be;

   logic           b_req, b_rw_n, b_ready, b_valid, b_err, b_init_done;
   logic [AWB-1:0] b_adr;
   logic [W-1:0]   b_data, b_rdata;
   logic [3:0]     b_be;

   rram_bank #(.WIDTH(W), .DEPTH(DA)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_req(req), .i_rw_n(rw_n), .i_adr(adr),
      .i_data(data), .i_be(be), .o_ready(ready), .o_valid(valid),
      .o_data(rdata), .o_err(err), .o_init_done(init_done));

   rram_bank #(.WIDTH(W), .DEPTH(DB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_req(b_req), .i_rw_n(b_rw_n), .i_adr(b_adr),
      .i_data(b_data), .i_be(b_be), .o_ready(b_ready), .o_valid(b_valid),
      .o_data(b_rdata), .o_err(b_err), .o_init_done(b_init_done));

   int checks = 0;
   int errors = 0;

   // Reference model: word contents plus per-byte "known" flags
   logic [W-1:0] mdl [DA];
   logic [3:0]   kn  [DA];

   task automatic model_reset();
      for (int i = 0; i < int'(DA); i++) begin
         mdl[i] = '0;
         kn[i]  = KN_RST;
      end
   endtask

   task automatic model_write(input logic [AWA-1:0] a, input logic [W-1:0] d, input logic [3:0] b);
      for (int k = 0; k < 4; k++) begin
         if (b[k]) begin
            mdl[a][8*k +: 8] = d[8*k +: 8];
            kn[a][k]         = 1'b1;
         end
      end
   endtask

   function automatic logic [W-1:0] mask_of(input logic [3:0] k);
      logic [W-1:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic step();
      @(posedge clk); #1;
      req   = 1'b0;
      b_req = 1'b0;
   endtask

   // Release reset and count cycles until ready, issuing requests that must be ignored
   task automatic release_and_count(input logic [AWA-1:0] wadr, output int cyc_n, output int vseen);
      @(negedge clk);
      rst_n = 1'b1;
      cyc_n = 0;
      vseen = 0;
      while (ready !== 1'b1 && cyc_n < int'(LIMIT)) begin
         req  = 1'b1;
         rw_n = cyc_n[0];
         adr  = wadr;
         data = $urandom;
         be   = 4'hF;
         @(posedge clk); #1;
         cyc_n++;
         if (valid || err) vseen++;
      end
      req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (rdata !== '0)       begin errors++; $display("FAIL reset_data got %h exp 0", rdata); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
      checks++; if (b_ready !== 1'b0)   begin errors++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
   endtask

   task automatic test_clear();
      int n, v;
      logic [AWA-1:0] alist [4];
      alist = '{AWA'(0), AWA'(5), AWA'(1023), AWA'(2047)};
      release_and_count(AWA'(5), n, v);
      model_reset();
      checks++; if (n != int'(INIT_CYC))  begin errors++; $display("FAIL clear_len got %0d exp %0d", n, INIT_CYC); end
      checks++; if (init_done !== 1'b1)   begin errors++; $display("FAIL clear_init_done got %b exp 1", init_done); end
      checks++; if (v != 0)               begin errors++; $display("FAIL clear_ignored got %0d exp 0", v); end
      checks++; if (b_init_done !== 1'b1) begin errors++; $display("FAIL clear_b_init_done got %b exp 1", b_init_done); end
`ifdef RRAM_BANK_INIT_CLEAR_EN
      for (int i = 0; i < 4; i++) begin
         req = 1'b1; rw_n = 1'b1; adr = alist[i];
         step();
         checks++; if (valid !== 1'b1 || rdata !== '0) begin
            errors++; $display("FAIL clear_read[%0d] got v=%b %h exp v=1 0", alist[i], valid, rdata);
         end
      end
`endif
   endtask

   task automatic test_byte_enable();
      req = 1'b1; rw_n = 1'b0; adr = AWA'(5); data = 32'hAABBCCDD; be = 4'hF;
      model_write(adr, data, be);
      step();
      req = 1'b1; rw_n = 1'b0; adr = AWA'(5); data = 32'h11223344; be = 4'b0101;
      model_write(adr, data, be);
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL be_write_valid got %b exp 0", valid); end
      req = 1'b1; rw_n = 1'b0; adr = AWA'(5); data = 32'h0; be = 4'h0;
      step();
      req = 1'b1; rw_n = 1'b1; adr = AWA'(5);
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL be_read_valid got %b exp 1", valid); end
      checks++; if (rdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_read_data got %h exp aa22cc44", rdata); end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL be_pulse got %b exp 0", valid); end
      checks++; if (rdata !== 32'hAA22CC44) begin errors++; $display("FAIL be_hold got %h exp aa22cc44", rdata); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         req = 1'b1; rw_n = 1'b0; adr = AWA'(i); data = 32'(i) * 32'h01010101; be = 4'hF;
         model_write(adr, data, be);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         req = 1'b1; rw_n = 1'b1; adr = AWA'(i);
         step();
         checks++; if (valid !== 1'b1 || rdata !== 32'(i) * 32'h01010101) begin
            errors++; $display("FAIL b2b_read[%0d] got v=%b %h exp v=1 %h", i, valid, rdata, 32'(i) * 32'h01010101);
         end
      end
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", valid); end
   endtask

   task automatic test_write_read();
      req = 1'b1; rw_n = 1'b0; adr = AWA'(3); data = 32'h12345678; be = 4'hF;
      model_write(adr, data, be);
      step();
      req = 1'b1; rw_n = 1'b1; adr = AWA'(3);
      step();
      checks++; if (valid !== 1'b1 || rdata !== 32'h12345678) begin
         errors++; $display("FAIL wr_rd got v=%b %h exp v=1 12345678", valid, rdata);
      end
      req = 1'b1; rw_n = 1'b0; adr = AWA'(3); data = 32'hCAFEF00D; be = 4'hF;
      model_write(adr, data, be);
      step();
      checks++; if (valid !== 1'b0 || rdata !== 32'h12345678) begin
         errors++; $display("FAIL wr_hold got v=%b %h exp v=0 12345678", valid, rdata);
      end
      req = 1'b1; rw_n = 1'b1; adr = AWA'(3);
      step();
      checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_rd2 got %h exp cafef00d", rdata); end
   endtask

   task automatic test_out_of_range();
      b_req = 1'b1; b_rw_n = 1'b0; b_adr = AWB'(999); b_data = 32'h5555AAAA; b_be = 4'hF;
      step();
      checks++; if (b_err !== 1'b0 || b_valid !== 1'b0) begin
         errors++; $display("FAIL oor_inrange_wr got e=%b v=%b exp e=0 v=0", b_err, b_valid);
      end
      b_req = 1'b1; b_rw_n = 1'b0; b_adr = AWB'(1000); b_data = 32'hDEADBEEF; b_be = 4'hF;
      step();
      checks++; if (b_err !== 1'b1 || b_valid !== 1'b0) begin
         errors++; $display("FAIL oor_wr got e=%b v=%b exp e=1 v=0", b_err, b_valid);
      end
      b_req = 1'b1; b_rw_n = 1'b1; b_adr = AWB'(1000);
      step();
      checks++; if (b_err !== 1'b1 || b_valid !== 1'b1 || b_rdata !== '0) begin
         errors++; $display("FAIL oor_rd got e=%b v=%b %h exp e=1 v=1 0", b_err, b_valid, b_rdata);
      end
      b_req = 1'b1; b_rw_n = 1'b1; b_adr = AWB'(999);
      step();
      checks++; if (b_err !== 1'b0 || b_valid !== 1'b1 || b_rdata !== 32'h5555AAAA) begin
         errors++; $display("FAIL oor_rd999 got e=%b v=%b %h exp e=0 v=1 5555aaaa", b_err, b_valid, b_rdata);
      end
      b_req = 1'b1; b_rw_n = 1'b1; b_adr = AWB'(1023);
      step();
      checks++; if (b_err !== 1'b1 || b_rdata !== '0) begin
         errors++; $display("FAIL oor_rd1023 got e=%b %h exp e=1 0", b_err, b_rdata);
      end
      step();
      checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", b_err); end
   endtask

   task automatic test_random();
      logic           r, rw, ev;
      logic [AWA-1:0] a;
      logic [W-1:0]   d, ed, em;
      logic [3:0]     b;
      ed = '0;
      em = '0;
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 3) != 0);
         rw = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? AWA'(DA - 1 - $urandom_range(0, 3)) : AWA'($urandom_range(0, 15));
         d  = $urandom;
         b  = 4'($urandom_range(0, 15));
         req = r; rw_n = rw; adr = a; data = d; be = b;
         if (r && !rw) model_write(a, d, b);
         ev = r && rw;
         if (ev) begin
            ed = mdl[a];
            em = mask_of(kn[a]);
         end
         step();
         checks++; if (valid !== ev || err !== 1'b0 || ((rdata ^ ed) & em) !== '0) begin
            errors++; $display("FAIL rand[%0d] got v=%b e=%b %h exp v=%b e=0 %h mask %h", n, valid, err, rdata, ev, ed, em);
         end
      end
   endtask

   task automatic test_async_reset();
      int n, v;
      req = 1'b1; rw_n = 1'b1; adr = AWA'(3);
      step();
      checks++; if (valid !== 1'b1 || rdata !== mdl[3]) begin
         errors++; $display("FAIL async_pre got v=%b %h exp v=1 %h", valid, rdata, mdl[3]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ready !== 1'b0 || valid !== 1'b0 || rdata !== '0 || init_done !== 1'b0 || b_ready !== 1'b0) begin
         errors++; $display("FAIL async_clr got r=%b v=%b %h d=%b br=%b exp all 0", ready, valid, rdata, init_done, b_ready);
      end
`ifdef RRAM_BANK_INIT_CLEAR_EN
      @(negedge clk);
      rst_n = 1'b1;
      repeat (500) step();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midinit_ready got %b exp 0", ready); end
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
`endif
      release_and_count(AWA'(10), n, v);
      model_reset();
      checks++; if (n != int'(INIT_CYC)) begin errors++; $display("FAIL rerun_len got %0d exp %0d", n, INIT_CYC); end
      checks++; if (v != 0)              begin errors++; $display("FAIL rerun_ignored got %0d exp 0", v); end
`ifdef RRAM_BANK_INIT_CLEAR_EN
      req = 1'b1; rw_n = 1'b1; adr = AWA'(10);
      step();
      checks++; if (valid !== 1'b1 || rdata !== '0) begin
         errors++; $display("FAIL rerun_rd10 got v=%b %h exp v=1 0", valid, rdata);
      end
      req = 1'b1; rw_n = 1'b1; adr = AWA'(3);
      step();
      checks++; if (rdata !== '0) begin errors++; $display("FAIL rerun_rd3 got %h exp 0", rdata); end
`endif
      req = 1'b1; rw_n = 1'b0; adr = AWA'(9); data = 32'h0BADCAFE; be = 4'hF;
      step();
      req = 1'b1; rw_n = 1'b1; adr = AWA'(9);
      step();
      checks++; if (valid !== 1'b1 || rdata !== 32'h0BADCAFE) begin
         errors++; $display("FAIL rerun_wr_rd got v=%b %h exp v=1 0badcafe", valid, rdata);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req = 1'b0; rw_n = 1'b1; adr = '0; data = '0; be = '0;
      b_req = 1'b0; b_rw_n = 1'b1; b_adr = '0; b_data = '0; b_be = '0;
      test_reset();
      test_clear();
      test_byte_enable();
      test_back_to_back();
      test_write_read();
      test_out_of_range();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
